gate2_bist: RTL and testbench
=============================

// Module: gate2_bist
// PURPOSE
//   On-chip exhaustive stimulus/response engine for any 2-input gate (default NAND2).
//   Drives the gate inputs, samples the gate output, compares it with a truth table and reports pass/fail.
//   Sits beside the gate under test as the hardware counterpart of the gate's stimulus bench.
//   Drives a/b and receives o.
// PARAMETERS
//   TRUTH          4'b0111  expected o per vector index {a,b}; bit i = expected o for idx i (NAND default)
//   SETTLE_CYCLES  2        cycles each vector is held before sampling; legal range 1..255
//   PASSES         1        full 4-vector sweeps per run; legal range 1..15
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  begin run; accepted only in IDLE
//   abort      in   1  synchronous abort; returns to IDLE
//   o          in   1  output of gate under test
//   a          out  1  gate input A, registered
//   b          out  1  gate input B, registered
//   busy       out  1  high while in APPLY/CHECK
//   done       out  1  one-cycle pulse at end of a completed run
//   pass       out  1  1 = last completed run had zero mismatches; held until next start
//   err_cnt    out  8  mismatch count, saturates at 255
//   fail_vec   out  4  bit i set if vector idx i mismatched in any sweep
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; a=b=busy=done=pass=0; err_cnt=0; fail_vec=0; internal counters 0.
//   FSM states: IDLE -> APPLY -> CHECK -> (APPLY | DONE) -> IDLE.
//   Vector index idx is 2 bits; a=idx[1], b=idx[0]; order 00,01,10,11 in every sweep.
//   IDLE:
//     start=1 at edge -> APPLY, idx=0, sweep=0, settle cnt=0, err_cnt=0, fail_vec=0, pass=0, busy=1.
//   APPLY:
//     holds a/b for exactly SETTLE_CYCLES cycles, then -> CHECK.
//   CHECK (1 cycle):
//     o compared with TRUTH[idx] at the edge leaving CHECK.
//     On mismatch: err_cnt+1 (saturating at 255) and fail_vec[idx] set.
//     If idx<3 or sweep<PASSES-1: idx wraps 3->0 and sweep increments, new a/b drive at that same edge, -> APPLY.
//     Otherwise -> DONE.
//   DONE (1 cycle):
//     done=1, busy=0, pass=(err_cnt==0); a=b=0 at next edge; -> IDLE.
//   Latency: done is high in the cycle beginning 4*PASSES*(SETTLE_CYCLES+1) edges after the start-accept edge.
//     Example: 12 edges for the defaults.
//   The CHECK of the final vector counts toward pass, i.e. pass accounts for a mismatch on the last vector.
//   start while busy or in DONE: ignored, no restart.
//   abort=1 in any non-IDLE state:
//     -> IDLE at that edge; a=b=0, busy=0, done not asserted, pass=0.
//     err_cnt and fail_vec keep their partial values.
//     abort has priority over start and over CHECK updates in the same cycle.
//   abort in IDLE: no effect.
//   rst_n asserted mid-run: immediate return to reset values; no done.
//   o is sampled directly; the gate under test is combinational, settled within SETTLE_CYCLES.
// TESTING
//   1. Good NAND, defaults; start pulse.
//      -> a,b = 00,01,10,11 each held 3 cycles; done 12 edges after accept; pass=1, err_cnt=0, fail_vec=0000.
//   2. o tied to 1, defaults.
//      -> mismatch only at idx 3; err_cnt=1, fail_vec=1000, pass=0.
//   3. o driven by an AND gate, defaults.
//      -> err_cnt=4, fail_vec=1111, pass=0.
//   4. PASSES=3, o tied to 0.
//      -> err_cnt=9, fail_vec=0111, pass=0; done 36 edges after accept.
//   5. Good NAND; abort at 5th cycle after accept.
//      -> IDLE next edge, a=b=0, busy=0, no done pulse.
//      Then a new start gives a full clean run with pass=1.
//   6. rst_n low for 1 cycle mid-APPLY -> all outputs 0 immediately.
//      start pulses while busy -> ignored, done timing unchanged.

Source files
------------

// File: rtl/gate2_bist.sv
// gate2_bist: exhaustive stimulus/response self-test for a 2-input combinational gate.
module gate2_bist #(
  parameter logic [3:0] TRUTH         = 4'b0111,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       o,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [3:0] fail_vec
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] sweep_q, sweep_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d, err_nx;
  logic [3:0] fv_q, fv_d, fv_nx;
  logic a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic mis, more;
  logic [1:0] nidx;
  assign mis    = o != TRUTH[idx_q];
  assign err_nx = (mis && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  assign fv_nx  = fv_q | ({3'b0, mis} << idx_q);
  assign more   = idx_q != 2'd3 || sweep_q != 4'(PASSES - 1);
  assign nidx   = idx_q + 2'd1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        idx_d   = 2'd0;
        sweep_d = 4'd0;
        cnt_d   = 8'd0;
        err_d   = 8'd0;
        fv_d    = 4'd0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      APPLY: begin
        state_d = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? CHECK : APPLY;
        cnt_d   = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? 8'd0 : cnt_q + 8'd1;
      end
      CHECK: begin
        err_d   = err_nx;
        fv_d    = fv_nx;
        state_d = more ? APPLY : DONE;
        idx_d   = more ? nidx : idx_q;
        sweep_d = (more && idx_q == 2'd3) ? sweep_q + 4'd1 : sweep_q;
        a_d     = more ? nidx[1] : a_q;
        b_d     = more ? nidx[0] : b_q;
        busy_d  = more;
        done_d  = !more;
        pass_d  = more ? pass_q : (err_nx == 8'd0);
      end
      default: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
    // abort wins over everything, but the partial error record is kept
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = err_q;
      fv_d    = fv_q;
      cnt_d   = 8'd0;
      a_d     = 1'b0;
      b_d     = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      sweep_q <= 4'd0;
      cnt_q   <= 8'd0;
      err_q   <= 8'd0;
      fv_q    <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fv_q;
endmodule

// File: tb/tb_gate2_bist.sv
// tb_gate2_bist: runs a default and a three-sweep instance against modelled gates.
module tb_gate2_bist;
  localparam int S = 2;
  localparam logic [3:0] TR = 4'b0111;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] tbl = TR;
  logic a1, b1, busy1, done1, pass1, a3, b3, busy3, done3, pass3, o1, o3;
  logic [7:0] err1, err3;
  logic [3:0] fv1, fv3;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign o1 = tbl[{a1, b1}];
  assign o3 = tbl[{a3, b3}];
  gate2_bist dut1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .o(o1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1));
  gate2_bist #(.PASSES(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .o(o3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .fail_vec(fv3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_err(input logic [3:0] t, input int p);
    int n;
    n = p * $countones(t ^ TR);
    return n > 255 ? 255 : n;
  endfunction

  // k = edges since the accepting edge; the model knows only sweep timing and the truth table
  task automatic cyc(input string tag, input int k, input int p, input logic [3:0] t,
                     input logic ab_a, input logic ab_b, input logic bs, input logic dn,
                     input logic ps, input logic [7:0] er, input logic [3:0] fv);
    int l;
    int idx;
    l = 4 * p * (S + 1);
    idx = k < l ? (k / (S + 1)) % 4 : (k == l ? 3 : 0);
    chk({tag, "_ab"}, {ab_a, ab_b}, idx);
    chk({tag, "_busy"}, bs, k < l);
    chk({tag, "_done"}, dn, k == l);
    if (k >= l) begin
      chk({tag, "_err"}, er, exp_err(t, p));
      chk({tag, "_fv"}, fv, t ^ TR);
      chk({tag, "_pass"}, ps, (t ^ TR) == 4'd0);
    end else chk({tag, "_pass_lo"}, ps, 0);
  endtask

  task automatic accept();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [3:0] t, input bit glitch);
    tbl = t;
    accept();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      cyc("p1", k, 1, t, a1, b1, busy1, done1, pass1, err1, fv1);
      cyc("p3", k, 3, t, a3, b3, busy3, done3, pass3, err3, fv3);
      start = glitch && (k == 5 || k == 8);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ab1"}, {a1, b1}, 0);
    chk({tag, "_bd1"}, {busy1, done1, pass1}, 0);
    chk({tag, "_ab3"}, {a3, b3}, 0);
    chk({tag, "_bd3"}, {busy3, done3, pass3}, 0);
  endtask

  initial begin
    logic [3:0] t, m;
    #1;
    idle_chk("reset");
    chk("reset_err", {err1, fv1, err3, fv3}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(4'b0111, 1'b1);
    run(4'b1111, 1'b0);
    run(4'b1000, 1'b0);
    run(4'b0000, 1'b0);
    // abort during APPLY of vector 1: only vector 0 has been checked
    t = 4'($urandom);
    tbl = t;
    m = t ^ TR;
    accept();
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    idle_chk("abort");
    chk("abort_err1", err1, {7'd0, m[0]});
    chk("abort_fv1", fv1, {3'd0, m[0]});
    chk("abort_err3", err3, {7'd0, m[0]});
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 idle_chk("abort_hold");
    end
    run(4'b0111, 1'b0);
    for (int i = 0; i < 6; i++) run(4'($urandom), i[0]);
    tbl = TR;
    accept();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 idle_chk("rst_mid");
    chk("rst_mid_err", {err1, fv1, err3, fv3}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 idle_chk("rst_hold");
    end
    run(4'b0111, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
